inst_fetch_unit: RTL

Instruction fetch front-end for the single-cycle RV32I core. It issues word-aligned requests to an instruction memory over a valid/ready request channel and accepts in-order responses. Responses are buffered in a small prefetch FIFO, and {pc, instruction} pairs are presented to the decode/execute stage over a valid/ready handshake. It handles control-flow redirects (taken branch, JAL, JALR) by flushing buffered words and squashing in-flight responses.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/inst_fetch_unit_if.sv | 32 +++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch front-end: widths, reset PC,
// the {pc, inst} entry carried through the prefetch FIFO, and a helper
// that forces an address onto a word boundary.
package rv32i_pkg;

    localparam int          XLEN             = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Drop the byte-offset bits; instruction fetch is always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the fetch unit's memory request/response channel, the
// instruction output handshake, and the redirect/enable controls.
// master = the fetch unit, slave = its environment (memory + core).
interface inst_fetch_unit_if;
    import rv32i_pkg::*;

    logic              fetch_en;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        input  fetch_en, imem_req_ready, imem_resp_valid, imem_resp_data,
               inst_ready, redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output fetch_en, imem_req_ready, imem_resp_valid, imem_resp_data,
               inst_ready, redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched {pc, inst} entries.
// Writes are registered (no write-to-read bypass); flush empties it in
// one cycle and wins over a same-cycle push or pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             pop_ok;

    // A pop on an empty FIFO is ignored rather than corrupting the pointers.
    assign pop_ok    = pop & (count_reg != '0);
    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: issues word-aligned requests under a
// credit limit, tags in-order responses with their PC, buffers them in
// the prefetch FIFO, and squashes everything in flight on a redirect.
module inst_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    inst_fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    // Wide enough to hold fifo_count + outstanding + discard without overflow.
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [SW-1:0]   credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            inst_valid;
    logic [XLEN-1:0] redirect_target;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign redirect_target = word_align(bus.redirect_pc);

    // Every accepted, non-discarded response is guaranteed a FIFO slot.
    assign credit_used = SW'(fifo_count) + SW'(outstanding_reg) + SW'(discard_reg);
    assign req_valid   = reset_n & bus.fetch_en & ~bus.redirect_valid
                       & (credit_used < SW'(FIFO_DEPTH));
    assign req_fire    = req_valid & bus.imem_req_ready;

    // A response arriving during a redirect belongs to the old stream.
    assign push       = bus.imem_resp_valid & (discard_reg == '0) & ~bus.redirect_valid;
    assign push_entry = '{pc: resp_pc_reg, inst: bus.imem_resp_data};

    assign inst_valid = ~fifo_empty;
    assign pop        = inst_valid & bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_reg;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_data      = head_entry.inst;
    assign bus.inst_pc        = head_entry.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Next-state for PCs and in-flight bookkeeping; redirect overrides everything.
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(bus.imem_resp_valid);
        discard_next     = discard_reg;
        if (bus.redirect_valid) begin
            fetch_pc_next = redirect_target;
            resp_pc_next  = redirect_target;
            // Everything still in flight after this edge belongs to the old stream.
            discard_next  = outstanding_reg - CW'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (push) begin
                resp_pc_next = resp_pc_reg + 32'd4;
            end
            if (bus.imem_resp_valid && (discard_reg != '0)) begin
                discard_next = discard_reg - CW'(1);
            end
        end
    end

    // State registers for PCs and the outstanding/discard counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

endmodule
